// File: rtl/tiny_imem_loader.sv
// rtl/tiny_imem_loader.sv - host-loaded instruction memory that releases the CPU once a program is in place
//
// Purpose:
//   Accepts a program from a host as a byte stream, writes it into a
//   2^ADDR_WIDTH-deep instruction memory and then releases the CPU (cpu_run).
//   The CPU fetches through a registered read port that works in every state.
//   The memory itself is never reset, so a shorter reload keeps the tail of a
//   previous program.
//
// Optional feature (macro IMEM_CHECKSUM_EN):
//   When defined, a running XOR of the accepted program bytes is kept. After
//   the last program byte one extra check byte is accepted (not stored, not
//   counted). If it matches, the CPU is released. If not, the block parks in
//   ERROR with load_err=1. When undefined, no checksum logic exists,
//   load_err is tied to 0 and LOAD goes straight to RUN.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   load_start   in   begin/restart a program load (wins over everything)
//   load_valid   in   load_data holds a byte
//   load_data    in   program byte (or check byte in CHECK)
//   load_last    in   current byte is the final program byte
//   load_ready   out  a byte is accepted this cycle when load_valid=1
//   fetch_en     in   CPU fetch strobe
//   fetch_addr   in   CPU program counter
//   fetch_data   out  registered instruction byte (1-cycle latency)
//   cpu_run      out  CPU released to execute
//   load_err     out  most recent load failed its integrity check
//   load_count   out  program bytes accepted in the current/most recent load

module tiny_imem_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  cpu_run,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Count value held just before the byte that fills the memory.
  localparam logic [ADDR_WIDTH:0] CNT_BEFORE_FULL = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

`ifdef IMEM_CHECKSUM_EN
  localparam state_t LOAD_EXIT = ST_CHECK;
`else
  localparam state_t LOAD_EXIT = ST_RUN;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]     load_count_q, load_count_d;
  logic [DATA_WIDTH-1:0]   fetch_data_q, fetch_data_d;
  logic                    mem_we;
  logic                    accept;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;
  logic                    load_err_q, load_err_d;
`endif

  assign load_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign cpu_run    = (state_q == ST_RUN);
  assign accept     = load_valid && load_ready;
  assign fetch_data = fetch_data_q;
  assign load_count = load_count_q;

`ifdef IMEM_CHECKSUM_EN
  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    load_count_d = load_count_q;
    fetch_data_d = fetch_data_q;
    mem_we       = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    csum_d       = csum_q;
    load_err_d   = load_err_q;
`endif

    // Read sees the pre-write contents because the memory write is
    // non-blocking; a same-cycle fetch/write returns the old byte.
    if (fetch_en) begin
      fetch_data_d = mem[fetch_addr];
    end

    if (load_start) begin
      // Restart from any state; a byte offered on this cycle is dropped.
      state_d      = ST_LOAD;
      wptr_d       = '0;
      load_count_d = '0;
`ifdef IMEM_CHECKSUM_EN
      csum_d       = '0;
      load_err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            mem_we       = 1'b1;
            load_count_d = load_count_q + 1'b1;
`ifdef IMEM_CHECKSUM_EN
            csum_d       = csum_q ^ load_data;
`endif
            if (load_last || (load_count_q == CNT_BEFORE_FULL)) begin
              // Pointer is left on the final address so it never wraps.
              state_d = LOAD_EXIT;
            end else begin
              wptr_d = wptr_q + 1'b1;
            end
          end
        end
`ifdef IMEM_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (load_data == csum_q) begin
              state_d = ST_RUN;
            end else begin
              state_d    = ST_ERROR;
              load_err_d = 1'b1;
            end
          end
        end
`endif
        ST_IDLE, ST_RUN, ST_ERROR: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      load_count_q <= '0;
      fetch_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      load_count_q <= load_count_d;
      fetch_data_q <= fetch_data_d;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      load_err_q <= load_err_d;
    end
  end
`endif

  // Program storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_q] <= load_data;
    end
  end

endmodule

// File: tb/tb_tiny_imem_loader.sv
// tb/tb_tiny_imem_loader.sv - randomized self-checking bench for tiny_imem_loader against a behavioural model
module tb_tiny_imem_loader;

  localparam int DEPTH = 16;
`ifdef IMEM_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       fetch_en;
  logic [3:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       cpu_run;
  logic       load_err;
  logic [4:0] load_count;

  int total = 0;
  int bad   = 0;

  tiny_imem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_run    (cpu_run),
    .load_err   (load_err),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the host has done so far, in plain terms.
  bit         m_loading, m_checking, m_running, m_err;
  int         m_count;
  logic [7:0] m_csum;
  logic [7:0] m_mem [DEPTH];
  bit         m_written [DEPTH];
  logic [7:0] m_fd;
  bit         m_fd_known;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_loading  = 0;
    m_checking = 0;
    m_running  = 0;
    m_err      = 0;
    m_count    = 0;
    m_csum     = 8'h00;
    m_fd       = 8'h00;
    m_fd_known = 1;
  endtask

  task automatic model_edge();
    logic [7:0] nfd;
    bit         nknown;
    nfd    = m_fd;
    nknown = m_fd_known;
    if (fetch_en) begin
      nfd    = m_mem[fetch_addr];
      nknown = m_written[fetch_addr];
    end
    if (load_start) begin
      m_loading  = 1;
      m_checking = 0;
      m_running  = 0;
      m_err      = 0;
      m_count    = 0;
      m_csum     = 8'h00;
    end else if (load_valid && m_loading) begin
      m_mem[m_count]     = load_data;
      m_written[m_count] = 1;
      m_count++;
      m_csum = m_csum ^ load_data;
      if (load_last || m_count == DEPTH) begin
        m_loading  = 0;
        m_checking = CK;
        m_running  = !CK;
      end
    end else if (load_valid && m_checking) begin
      m_checking = 0;
      if (load_data == m_csum) m_running = 1;
      else m_err = 1;
    end
    m_fd       = nfd;
    m_fd_known = nknown;
  endtask

  task automatic check_all();
    check_val("cpu_run", cpu_run, m_running);
    check_val("load_ready", load_ready, m_loading || m_checking);
    check_val("load_count", load_count, m_count);
    check_val("load_err", load_err, m_err);
    if (m_fd_known) check_val("fetch_data", fetch_data, m_fd);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    load_start = 0;
    load_valid = 0;
    load_data  = 8'h00;
    load_last  = 0;
    fetch_en   = 0;
    fetch_addr = 4'h0;
  endtask

  task automatic start_load();
    load_start = 1;
    tick();
    load_start = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    load_valid = 1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 0;
    load_last  = 0;
  endtask

  task automatic fetch(input logic [3:0] a);
    fetch_en   = 1;
    fetch_addr = a;
    tick();
    fetch_en   = 0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    rst = 1;
    #1;
    check_val({tag, "_run"}, cpu_run, 1'b0);
    check_val({tag, "_fd"}, fetch_data, 8'h00);
    check_val({tag, "_rdy"}, load_ready, 1'b0);
    check_val({tag, "_cnt"}, load_count, 5'd0);
    check_val({tag, "_err"}, load_err, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_written[i] = 0;
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 0;
    tick();

    // Three-byte program, fetch back the last byte.
    start_load();
    send_byte(8'h88, 0);
    send_byte(8'h91, 0);
    send_byte(8'h19, 1);
    check_val("p1_cnt", load_count, 5'd3);
    if (CK) send_byte(8'h00, 0);
    check_val("p1_run", cpu_run, 1'b1);
    fetch(4'd2);
    check_val("p1_fetch", fetch_data, 8'h19);

    // Full 16-byte load without load_last; extra byte is refused.
    start_load();
    for (int i = 0; i < DEPTH; i++) send_byte(i[7:0], 0);
    check_val("full_cnt", load_count, 5'd16);
    if (!CK) begin
      check_val("full_run", cpu_run, 1'b1);
      check_val("full_rdy", load_ready, 1'b0);
    end
    send_byte(8'hAA, 0);
    check_val("full_cnt17", load_count, 5'd16);
    fetch(4'd15);
    check_val("full_fetch15", fetch_data, 8'h0F);

    // Restart mid-load with a coincident byte.
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'h40 + i[7:0], 0);
    load_start = 1;
    send_byte(8'h77, 0);
    load_start = 0;
    check_val("rs_cnt", load_count, 5'd0);
    check_val("rs_run", cpu_run, 1'b0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 1);
    check_val("rs_cnt2", load_count, 5'd2);
    if (CK) send_byte(8'hFF, 0);
    fetch(4'd0);
    check_val("rs_fetch0", fetch_data, 8'h5A);

    // Integrity check pass and fail.
    if (CK) begin
      start_load();
      send_byte(8'h88, 0);
      send_byte(8'h91, 1);
      send_byte(8'h19, 0);
      check_val("ck_pass_run", cpu_run, 1'b1);
      start_load();
      send_byte(8'h88, 0);
      send_byte(8'h91, 1);
      send_byte(8'h20, 0);
      check_val("ck_fail_err", load_err, 1'b1);
      check_val("ck_fail_run", cpu_run, 1'b0);
      start_load();
      check_val("ck_err_clr", load_err, 1'b0);
    end

    // Same-cycle fetch and write at address 4 returns the old byte.
    start_load();
    for (int i = 0; i < 4; i++) send_byte(8'h10 + i[7:0], 0);
    send_byte(8'hD8, 1);
    if (CK) send_byte(8'h10 ^ 8'h11 ^ 8'h12 ^ 8'h13 ^ 8'hD8, 0);
    start_load();
    for (int i = 0; i < 4; i++) send_byte(8'h20 + i[7:0], 0);
    fetch_en   = 1;
    fetch_addr = 4'd4;
    send_byte(8'h3C, 1);
    check_val("rw_old", fetch_data, 8'hD8);
    fetch(4'd4);
    check_val("rw_new", fetch_data, 8'h3C);
    fetch(4'd4);
    fetch_en = 0;

    // Reset while running, then memory must survive.
    check_val("pre_rst_run", cpu_run, !CK);
    if (CK) send_byte(8'h20 ^ 8'h21 ^ 8'h22 ^ 8'h23 ^ 8'h3C, 0);
    async_reset("arst_run");
    fetch(4'd4);
    check_val("mem_keep", fetch_data, 8'h3C);

    // Reset mid-load abandons it.
    start_load();
    send_byte(8'h01, 0);
    async_reset("arst_load");
    send_byte(8'h02, 1);
    check_val("arst_noload", load_count, 5'd0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 699) begin
        async_reset("arst_rnd");
      end
      if (m_loading || m_checking) load_start = ($urandom_range(0, 49) == 0);
      else load_start = ($urandom_range(0, 7) == 0);
      load_valid = ($urandom_range(0, 9) < 7);
      load_data  = 8'($urandom);
      if (m_checking && $urandom_range(0, 1) == 1) load_data = m_csum;
      load_last  = ($urandom_range(0, 5) == 0);
      fetch_en   = ($urandom_range(0, 1) == 1);
      fetch_addr = 4'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
